// File: rtl/uart_rx_ctrl_pkg.sv
// ============================================================================
// Module  : uart_rx_ctrl_pkg
// Brief   : Shared error-flag indices, FIFO entry layout and sequencer states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_rx_ctrl_pkg;

    localparam int ERR_PARITY  = 0;
    localparam int ERR_FRAMING = 1;
    localparam int ENTRY_W     = 10;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_ARMED  = 2'd1,
        ST_FRAME  = 2'd2,
        ST_COMMIT = 2'd3
    } ctrl_state_t;

    // FIFO entry: error flags above the received byte.
    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [1:0] err,
                                                      input logic [7:0] data);
        return {err, data};
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_ctrl_fifo.sv
// ============================================================================
// Module  : uart_rx_ctrl_fifo
// Brief   : Synchronous FIFO with push/pop/full/empty/level; push accepted when
//           full only if a pop happens in the same cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_ctrl_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int            c_aw      = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full_lv = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_full_lv);
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_level   = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// Module  : uart_rx_ctrl
// Brief   : Frame sequencer for uart_rx: gates enable, shadows parity config
//           between frames and queues each byte with its error flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int p_fifo_depth    = 4,
    parameter int p_frame_timeout = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            cfg_enable_i,
    input  logic                            cfg_parity_en_i,
    input  logic                            cfg_parity_sel_i,
    input  logic                            clear_i,
    input  logic                            rx_busy_i,
    input  logic                            rx_data_ready_i,
    input  logic [7:0]                      rx_data_i,
    input  logic                            rx_parity_err_i,
    input  logic                            rx_framing_err_i,
    output logic                            rx_enable_o,
    output logic                            rx_parity_en_o,
    output logic                            rx_parity_sel_o,
    output logic                            m_valid_o,
    output logic [7:0]                      m_data_o,
    output logic [1:0]                      m_err_o,
    input  logic                            m_ready_i,
    output logic [$clog2(p_fifo_depth):0]   level_o,
    output logic                            overrun_o,
    output logic                            timeout_o
);

    localparam int              c_tw       = (p_frame_timeout > 0) ? $clog2(p_frame_timeout + 1) : 1;
    localparam logic [c_tw-1:0] c_tmo_last = c_tw'((p_frame_timeout > 0) ? p_frame_timeout - 1 : 0);

    ctrl_state_t          r_state;
    ctrl_state_t          w_state_nxt;
    logic                 r_dr_prev;
    logic                 r_busy_prev;
    logic [7:0]           r_hold;
    logic                 r_got;
    logic [1:0]           r_err_acc;
    logic                 r_par_en;
    logic                 r_par_sel;
    logic                 r_overrun;
    logic                 r_timeout;
    logic [c_tw-1:0]      r_tcnt;

    logic                 w_dr_rise;
    logic                 w_busy_fall;
    logic                 w_tmo_hit;
    logic [1:0]           w_err_now;
    logic                 w_rx_en;
    logic                 w_commit;
    logic                 w_abort;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_overrun_set;
    logic [ENTRY_W-1:0]   w_head;

    assign w_dr_rise   = rx_data_ready_i & ~r_dr_prev;
    assign w_busy_fall = ~rx_busy_i & r_busy_prev;
    assign w_tmo_hit   = (p_frame_timeout != 0) && (r_tcnt == c_tmo_last);

    always_comb begin
        w_err_now              = '0;
        w_err_now[ERR_PARITY]  = rx_parity_err_i;
        w_err_now[ERR_FRAMING] = rx_framing_err_i;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rx_en     = 1'b0;
        w_commit    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (cfg_enable_i && !rx_busy_i) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                w_rx_en = cfg_enable_i;
                if (rx_busy_i) begin
                    w_state_nxt = ST_FRAME;
                end else if (!cfg_enable_i) begin
                    w_state_nxt = ST_OFF;
                end
            end
            ST_FRAME: begin
                // A byte arriving on the very cycle busy drops still counts.
                if (w_busy_fall) begin
                    w_state_nxt = (r_got | w_dr_rise) ? ST_COMMIT : ST_ARMED;
                end else if (w_tmo_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_OFF;
                end
            end
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = cfg_enable_i ? ST_ARMED : ST_OFF;
            end
            default: w_state_nxt = ST_OFF;
        endcase
    end

    assign w_pop         = ~w_empty & m_ready_i;
    assign w_overrun_set = w_commit & w_full & ~w_pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_OFF;
            r_dr_prev   <= 1'b0;
            r_busy_prev <= 1'b0;
            r_hold      <= '0;
            r_got       <= 1'b0;
            r_err_acc   <= '0;
            r_par_en    <= 1'b0;
            r_par_sel   <= 1'b0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;
            r_tcnt      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_dr_prev   <= rx_data_ready_i;
            r_busy_prev <= rx_busy_i;

            if (r_state == ST_ARMED) begin
                r_par_en  <= cfg_parity_en_i;
                r_par_sel <= cfg_parity_sel_i;
            end

            // Frame-scoped capture; anything outside a frame starts clean.
            if (r_state == ST_FRAME) begin
                r_err_acc <= r_err_acc | w_err_now;
                r_tcnt    <= r_tcnt + 1'b1;
                if (w_dr_rise) begin
                    r_hold <= rx_data_i;
                    r_got  <= 1'b1;
                end
            end else begin
                r_err_acc <= '0;
                r_got     <= 1'b0;
                r_tcnt    <= '0;
            end

            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (clear_i) begin
                r_overrun <= 1'b0;
            end

            if (w_abort) begin
                r_timeout <= 1'b1;
            end else if (clear_i) begin
                r_timeout <= 1'b0;
            end
        end
    end

    uart_rx_ctrl_fifo #(
        .DEPTH (p_fifo_depth),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_commit),
        .i_data  (pack_entry(r_err_acc, r_hold)),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level_o)
    );

    assign rx_enable_o     = w_rx_en;
    assign rx_parity_en_o  = r_par_en;
    assign rx_parity_sel_o = r_par_sel;
    assign m_valid_o       = ~w_empty;
    assign m_data_o        = w_empty ? 8'h00 : w_head[7:0];
    assign m_err_o         = w_empty ? 2'b00 : w_head[9:8];
    assign overrun_o       = r_overrun;
    assign timeout_o       = r_timeout;

endmodule

`default_nettype wire
